pending_pair_dispatcher: RTL and testbench

Sequential consumer of lsb_second_bit_set_finder. Accumulates single-cycle request pulses into a pending bit vector. Each dispatch takes the lowest and second-lowest set pending bits as two one-hot grants, and issues them through a valid/ready handshake. It then clears the dispatched bits from the pending vector. It sits between request sources and a dual-issue downstream servicer.

---
 rtl/pending_pair_pkg.sv | 13 +
 rtl/lsb_second_bit_set_finder.sv | 16 +
 rtl/pending_pair_dispatcher.sv | 117 +++++++++++
 tb/tb_pending_pair_dispatcher.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pending_pair_pkg.sv
// Shared types and constants for the pending pair dispatcher.
// The optional merge counter is enabled by defining PENDING_PAIR_MERGE_CNT_EN.
package pending_pair_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    localparam int MERGE_CNT_W   = 16;
    localparam int DEFAULT_WIDTH = 12;

endpackage

// File: rtl/lsb_second_bit_set_finder.sv
// Isolates the second-lowest set bit of a vector as a one-hot value.
// The result is zero when fewer than two bits are set.
module lsb_second_bit_set_finder #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] second_bit
);

    logic [WIDTH-1:0] rest;

    // Drop the lowest set bit, then isolate the lowest of what remains.
    assign rest       = data & (data - WIDTH'(1));
    assign second_bit = rest & (~rest + WIDTH'(1));

endmodule

// File: rtl/pending_pair_dispatcher.sv
// Collects request pulses into a pending vector and dispatches the two lowest pending bits per handshake.
// Defining PENDING_PAIR_MERGE_CNT_EN adds merge_cnt_o, a saturating count of cycles with colliding requests.
module pending_pair_dispatcher
    import pending_pair_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] req_i,
    input  logic             flush_i,
    output logic             disp_valid_o,
    input  logic             disp_ready_i,
    output logic [WIDTH-1:0] first_o,
    output logic [WIDTH-1:0] second_o,
    output logic             pair_o,
    output logic [WIDTH-1:0] pending_o
`ifdef PENDING_PAIR_MERGE_CNT_EN
    ,
    output logic [MERGE_CNT_W-1:0] merge_cnt_o
`endif
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pending_reg, pending_next;
    logic [WIDTH-1:0] first_reg, second_reg;
    logic             pair_reg;

    logic [WIDTH-1:0] lowest, second, load_mask;
    logic             load;

    assign lowest = pending_reg & (~pending_reg + WIDTH'(1));

    lsb_second_bit_set_finder #(
        .WIDTH(WIDTH)
    ) u_second_finder (
        .data      (pending_reg),
        .second_bit(second)
    );

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pending_reg != '0) begin
                    load       = 1'b1;
                    state_next = VALID;
                end
            end
            VALID: begin
                if (disp_ready_i) begin
                    if (pending_reg != '0) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bits re-requested in the load cycle survive because req_i is ORed after the clear.
    assign load_mask    = load ? (lowest | second) : '0;
    assign pending_next = (pending_reg & ~load_mask) | req_i;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            first_reg   <= '0;
            second_reg  <= '0;
            pair_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            if (load) begin
                first_reg  <= lowest;
                second_reg <= second;
                pair_reg   <= |second;
            end else if (state_next == IDLE) begin
                first_reg  <= '0;
                second_reg <= '0;
                pair_reg   <= 1'b0;
            end
        end
    end

    assign disp_valid_o = (state_reg == VALID);
    assign first_o      = first_reg;
    assign second_o     = second_reg;
    assign pair_o       = pair_reg;
    assign pending_o    = pending_reg;

`ifdef PENDING_PAIR_MERGE_CNT_EN
    logic [MERGE_CNT_W-1:0] merge_cnt_reg, merge_cnt_next;

    always_comb begin
        merge_cnt_next = merge_cnt_reg;
        if (((req_i & pending_reg) != '0) && (merge_cnt_reg != '1)) begin
            merge_cnt_next = merge_cnt_reg + MERGE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            merge_cnt_reg <= '0;
        end else begin
            merge_cnt_reg <= merge_cnt_next;
        end
    end

    assign merge_cnt_o = merge_cnt_reg;
`endif

endmodule

// File: tb/tb_pending_pair_dispatcher.sv
// Self-checking bench: directed literal checks plus randomized traffic against a queue-free bit-scan model.
// Covers the optional merge counter when PENDING_PAIR_MERGE_CNT_EN is defined.
module tb_pending_pair_dispatcher;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] req_i = '0;
    logic         flush_i = 1'b0;
    logic         disp_ready_i = 1'b0;
    logic         disp_valid_o;
    logic [W-1:0] first_o, second_o, pending_o;
    logic         pair_o;
`ifdef PENDING_PAIR_MERGE_CNT_EN
    logic [15:0]  merge_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state
    logic [W-1:0] m_pend = '0, m_first = '0, m_second = '0;
    bit           m_valid = 1'b0;
    logic [15:0]  m_merge = '0;

    pending_pair_dispatcher #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .flush_i     (flush_i),
        .disp_valid_o(disp_valid_o),
        .disp_ready_i(disp_ready_i),
        .first_o     (first_o),
        .second_o    (second_o),
        .pair_o      (pair_o),
        .pending_o   (pending_o)
`ifdef PENDING_PAIR_MERGE_CNT_EN
        ,
        .merge_cnt_o (merge_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic int lowest_idx(input logic [W-1:0] v);
        for (int i = 0; i < W; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: scan for the two lowest pending bits whenever the slot is free or being accepted.
    always @(posedge clk) begin : model_upd
        logic [W-1:0] p, f, s;
        logic [15:0]  mg;
        bit           v;
        int           a, b;
        p = m_pend; f = m_first; s = m_second; v = m_valid; mg = m_merge;
        if (reset || flush_i) begin
            p = '0; f = '0; s = '0; v = 1'b0; mg = '0;
        end else begin
            if (((req_i & m_pend) != '0) && (mg != 16'hffff)) mg = mg + 16'd1;
            if ((p != '0) && (!v || disp_ready_i)) begin
                a = lowest_idx(p);
                p[a] = 1'b0;
                b = lowest_idx(p);
                f = '0; f[a] = 1'b1;
                s = '0;
                if (b >= 0) begin
                    s[b] = 1'b1;
                    p[b] = 1'b0;
                end
                v = 1'b1;
            end else if (v && disp_ready_i) begin
                v = 1'b0; f = '0; s = '0;
            end
            p = p | req_i;
        end
        m_pend   <= p;
        m_first  <= f;
        m_second <= s;
        m_valid  <= v;
        m_merge  <= mg;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid", 32'(disp_valid_o), 32'(m_valid));
            chk("pending", 32'(pending_o), 32'(m_pend));
            chk("first", 32'(first_o), 32'(m_first));
            chk("second", 32'(second_o), 32'(m_second));
            chk("pair", 32'(pair_o), 32'(m_second != '0));
`ifdef PENDING_PAIR_MERGE_CNT_EN
            chk("merge_cnt", 32'(merge_cnt_o), 32'(m_merge));
`endif
            if (pair_o) chk("order", 32'(first_o < second_o), 32'd1);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] ef [4];
    logic [W-1:0] es [4];

    initial begin
        ef = '{12'h010, 12'h040, 12'h100, 12'h400};
        es = '{12'h020, 12'h080, 12'h200, 12'h800};

        // 1: reset with all requests asserted
        reset = 1'b1; req_i = 12'hfff;
        cyc(); cyc();
        cmp_en = 1'b1;
        chk("rst_valid", 32'(disp_valid_o), 32'd0);
        chk("rst_pending", 32'(pending_o), 32'h000);
        chk("rst_first", 32'(first_o), 32'h000);
        chk("rst_second", 32'(second_o), 32'h000);

        // 2: single pair
        reset = 1'b0; req_i = 12'h003; disp_ready_i = 1'b1;
        cyc();
        chk("t2_pending", 32'(pending_o), 32'h003);
        req_i = '0;
        cyc();
        chk("t2_valid", 32'(disp_valid_o), 32'd1);
        chk("t2_first", 32'(first_o), 32'h001);
        chk("t2_second", 32'(second_o), 32'h002);
        chk("t2_pair", 32'(pair_o), 32'd1);
        cyc();
        chk("t2_idle", 32'(disp_valid_o), 32'd0);
        chk("t2_pend0", 32'(pending_o), 32'h000);

        // 3: back-to-back dispatch
        req_i = 12'hff0;
        cyc();
        req_i = '0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t3_first", 32'(first_o), 32'(ef[k]));
            chk("t3_second", 32'(second_o), 32'(es[k]));
        end
        cyc();
        chk("t3_idle", 32'(disp_valid_o), 32'd0);

        // 4: lone top bit
        req_i = 12'h800;
        cyc();
        req_i = '0;
        cyc();
        chk("t4_first", 32'(first_o), 32'h800);
        chk("t4_second", 32'(second_o), 32'h000);
        chk("t4_pair", 32'(pair_o), 32'd0);
        cyc();

        // 5: backpressure
        disp_ready_i = 1'b0; req_i = 12'h003;
        cyc();
        req_i = '0;
        cyc();
        req_i = 12'h00c;
        cyc();
        req_i = '0;
        chk("t5_first_hold", 32'(first_o), 32'h001);
        chk("t5_second_hold", 32'(second_o), 32'h002);
        chk("t5_pending", 32'(pending_o), 32'h00c);
        cyc();
        chk("t5_still", 32'(first_o), 32'h001);
        disp_ready_i = 1'b1;
        cyc();
        chk("t5_next_first", 32'(first_o), 32'h004);
        chk("t5_next_second", 32'(second_o), 32'h008);
        cyc();
        chk("t5_idle", 32'(disp_valid_o), 32'd0);

        // 6: flush with a colliding request beforehand
        disp_ready_i = 1'b0; req_i = 12'h003;
        cyc();
        req_i = 12'hf00;
        cyc();
        chk("t6_pending", 32'(pending_o), 32'hf00);
        chk("t6_valid", 32'(disp_valid_o), 32'd1);
        req_i = 12'h100;
        cyc();
`ifdef PENDING_PAIR_MERGE_CNT_EN
        chk("t6_merge1", 32'(merge_cnt_o), 32'd1);
`endif
        flush_i = 1'b1; req_i = 12'h001;
        cyc();
        flush_i = 1'b0; req_i = '0;
        chk("t6_flush_pending", 32'(pending_o), 32'h000);
        chk("t6_flush_valid", 32'(disp_valid_o), 32'd0);
`ifdef PENDING_PAIR_MERGE_CNT_EN
        chk("t6_merge0", 32'(merge_cnt_o), 32'd0);
`endif

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            req_i        = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
            disp_ready_i = ($urandom_range(0, 3) != 0);
            flush_i      = ($urandom_range(0, 80) == 0);
            reset        = ($urandom_range(0, 200) == 0);
            cyc();
        end
        reset = 1'b0; flush_i = 1'b0; req_i = '0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
